// File: rtl/fft_input_loader.sv
// fft_input_loader
// Collects one complex sample per cycle into a two-bank register buffer and
// presents each complete 2**POW-point frame in parallel to the FFT core.
// One bank can fill while the core is still holding the frame in the other.
module fft_input_loader #(
  parameter int DATA_WIDTH = 16,
  parameter int POW        = 3
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   sink_valid,
  output logic                                   sink_ready,
  input  logic                                   sink_sop,
  input  logic [DATA_WIDTH-1:0]                  sink_r,
  input  logic [DATA_WIDTH-1:0]                  sink_i,
  output logic                                   source_valid,
  input  logic                                   source_ready,
  output logic [(1<<POW)-1:0][DATA_WIDTH-1:0]    source_r,
  output logic [(1<<POW)-1:0][DATA_WIDTH-1:0]    source_i,
  output logic                                   sop_err
);

  localparam int              N        = 1 << POW;
  localparam logic [POW-1:0]  LAST_IDX = POW'(N - 1);
  localparam logic [POW-1:0]  CNT_ONE  = POW'(1);

  typedef logic [N-1:0][DATA_WIDTH-1:0] frame_t;

  // Frame storage and bookkeeping
  frame_t [1:0]   bank_r_q, bank_r_d;
  frame_t [1:0]   bank_i_q, bank_i_d;
  logic   [1:0]   full_q, full_d;
  logic           wr_bank_q, wr_bank_d;
  logic           rd_bank_q, rd_bank_d;
  logic [POW-1:0] wr_cnt_q, wr_cnt_d;
  logic           sop_err_q, sop_err_d;

  logic           accept;
  logic           pop;
  logic [POW-1:0] wr_idx;

  // Handshake decode: readiness depends only on state, never on sink_valid
  always_comb begin
    sink_ready   = !rst && !full_q[wr_bank_q];
    source_valid = full_q[rd_bank_q];
    accept       = sink_valid && sink_ready;
    pop          = source_valid && source_ready;
    wr_idx       = sink_sop ? '0 : wr_cnt_q;
  end

  // Next-state: sample write, frame completion and frame pop
  always_comb begin
    // NOTE: every signal gets its hold value first so no path leaves it
    // unassigned; a missing default here would infer a latch.
    bank_r_d  = bank_r_q;
    bank_i_d  = bank_i_q;
    full_d    = full_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    wr_cnt_d  = wr_cnt_q;
    sop_err_d = 1'b0;

    if (accept) begin
      bank_r_d[wr_bank_q][wr_idx] = sink_r;
      bank_i_d[wr_bank_q][wr_idx] = sink_i;
      // A start marker mid-frame restarts the bank; the stale samples are
      // overwritten before the frame can ever complete.
      sop_err_d = sink_sop && (wr_cnt_q != '0);
      if (wr_idx == LAST_IDX) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = !wr_bank_q;
        wr_cnt_d          = '0;
      end else begin
        wr_cnt_d = wr_idx + CNT_ONE;
      end
    end

    // The bank being completed is never the one being popped: a write needs
    // full[wr_bank]=0 while a pop needs full[rd_bank]=1.
    if (pop) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = !rd_bank_q;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    // NOTE: the sample banks are reset too, because the core sees them
    // directly on source_r/source_i and must read zeros after reset.
    if (rst) begin
      bank_r_q  <= '0;
      bank_i_q  <= '0;
      full_q    <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_cnt_q  <= '0;
      sop_err_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge value of the others, independent of statement order.
      bank_r_q  <= bank_r_d;
      bank_i_q  <= bank_i_d;
      full_q    <= full_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      wr_cnt_q  <= wr_cnt_d;
      sop_err_q <= sop_err_d;
    end
  end

  assign source_r = bank_r_q[rd_bank_q];
  assign source_i = bank_i_q[rd_bank_q];
  assign sop_err  = sop_err_q;

endmodule

// File: tb/tb_fft_input_loader.sv
// Testbench for fft_input_loader (DATA_WIDTH=16, POW=3).
// A frame-queue reference model runs alongside every cycle; directed
// sequences add explicit expectations for the corner cases.
module tb_fft_input_loader;

  localparam int DW = 16;
  localparam int N  = 8;

  logic               clk = 1'b0;
  logic               rst;
  logic               sink_valid, sink_ready, sink_sop;
  logic [DW-1:0]      sink_r, sink_i;
  logic               source_valid, source_ready;
  logic [N-1:0][DW-1:0] source_r, source_i;
  logic               sop_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fft_input_loader #(.DATA_WIDTH(DW), .POW(3)) dut (
    .clk(clk), .rst(rst),
    .sink_valid(sink_valid), .sink_ready(sink_ready), .sink_sop(sink_sop),
    .sink_r(sink_r), .sink_i(sink_i),
    .source_valid(source_valid), .source_ready(source_ready),
    .source_r(source_r), .source_i(source_i),
    .sop_err(sop_err)
  );

  // Reference model: a queue of completed frames (at most two) plus the
  // frame currently being assembled.
  typedef struct packed {
    logic [N-1:0][DW-1:0] r;
    logic [N-1:0][DW-1:0] i;
  } frame_t;

  frame_t m_q[$];
  frame_t m_part;
  int     m_cnt;
  bit     m_err;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, check readiness, advance model, check outputs.
  task automatic cycle(input bit v, input bit s, input logic [DW-1:0] r,
                       input logic [DW-1:0] im, input bit rdy, input bit rs,
                       output bit acc);
    bit exp_rdy, pp;
    int idx;
    sink_valid = v; sink_sop = s; sink_r = r; sink_i = im;
    source_ready = rdy; rst = rs;
    #1;
    exp_rdy = !rs && (m_q.size() < 2);
    check("sink_ready", sink_ready, exp_rdy);
    acc = 1'b0;
    @(posedge clk);
    if (rs) begin
      m_q.delete();
      m_cnt  = 0;
      m_err  = 1'b0;
      m_part = '0;
    end else begin
      acc   = v && exp_rdy;
      pp    = (m_q.size() > 0) && rdy;
      m_err = acc && s && (m_cnt != 0);
      if (pp) void'(m_q.pop_front());
      if (acc) begin
        idx = s ? 0 : m_cnt;
        m_part.r[idx] = r;
        m_part.i[idx] = im;
        if (idx == N - 1) begin
          m_q.push_back(m_part);
          m_cnt = 0;
        end else begin
          m_cnt = idx + 1;
        end
      end
    end
    #1;
    check("source_valid", source_valid, m_q.size() > 0);
    check("sop_err", sop_err, m_err);
    if (m_q.size() > 0) begin
      check("source_r", source_r, m_q[0].r);
      check("source_i", source_i, m_q[0].i);
    end
  endtask

  // Offer a sample until it is accepted, bounded.
  task automatic send(input logic [DW-1:0] r, input logic [DW-1:0] im, input bit s, input bit rdy);
    bit acc;
    int n = 0;
    do begin
      cycle(1'b1, s, r, im, rdy, 1'b0, acc);
      n++;
    end while (!acc && n < 50);
    if (!acc) check("send_timeout", 1'b0, 1'b1);
  endtask

  task automatic idle(input bit rdy);
    bit acc;
    cycle(1'b0, 1'b0, '0, '0, rdy, 1'b0, acc);
  endtask

  task automatic do_reset();
    bit acc;
    cycle(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, acc);
    cycle(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, acc);
    idle(1'b0);
  endtask

  typedef struct {
    bit            sop;
    logic [DW-1:0] r;
    logic [DW-1:0] im;
    bit            exp_ready;
    bit            exp_valid;
  } vec_t;

  initial begin
    vec_t  tbl[N];
    bit    acc;
    int    frames;
    logic [DW-1:0] e;

    for (int k = 0; k < N; k++) begin
      tbl[k].sop       = (k == 0);
      tbl[k].r         = DW'(k);
      tbl[k].im        = DW'(-k);
      tbl[k].exp_ready = 1'b1;
      tbl[k].exp_valid = (k == N - 1);
    end

    // Reset state
    m_q.delete(); m_cnt = 0; m_err = 0; m_part = '0;
    do_reset();
    check("rst_valid", source_valid, 1'b0);
    check("rst_ready", sink_ready, 1'b1);
    check("rst_src_r", source_r, '0);
    check("rst_src_i", source_i, '0);
    check("rst_sop_err", sop_err, 1'b0);

    // 1: single frame r=k, i=-k
    for (int k = 0; k < N; k++) begin
      send(tbl[k].r, tbl[k].im, tbl[k].sop, 1'b0);
      check("t1_valid", source_valid, tbl[k].exp_valid);
      check("t1_ready", sink_ready, tbl[k].exp_ready);
    end
    for (int k = 0; k < N; k++) begin
      e = DW'(-k);
      check("t1_r", source_r[k], DW'(k));
      check("t1_i", source_i[k], e);
    end

    // 2: back-pressure with both banks full
    do_reset();
    for (int k = 0; k < 16; k++) send(DW'(k), DW'(-k), (k % 8) == 0, 1'b0);
    check("t2_ready_low", sink_ready, 1'b0);
    check("t2_frame1_r0", source_r[0], DW'(0));
    for (int c = 0; c < 3; c++) begin
      cycle(1'b1, 1'b1, DW'(16), DW'(-16), 1'b0, 1'b0, acc);
      check("t2_blocked", acc, 1'b0);
    end
    cycle(1'b1, 1'b1, DW'(16), DW'(-16), 1'b1, 1'b0, acc);
    check("t2_pop_noacc", acc, 1'b0);
    check("t2_frame2_r0", source_r[0], DW'(8));
    check("t2_frame2_r7", source_r[7], DW'(15));
    check("t2_ready_back", sink_ready, 1'b1);
    cycle(1'b1, 1'b1, DW'(16), DW'(-16), 1'b0, 1'b0, acc);
    check("t2_s16_acc", acc, 1'b1);
    for (int k = 17; k < 24; k++) send(DW'(k), DW'(-k), 1'b0, 1'b0);
    check("t2_ready_full", sink_ready, 1'b0);

    // 3: continuous stream, frames popped immediately
    do_reset();
    frames = 0;
    for (int k = 0; k < 32; k++) begin
      cycle(1'b1, (k % 8) == 0, DW'(k * 3), DW'(k), 1'b1, 1'b0, acc);
      check("t3_acc", acc, 1'b1);
      if (source_valid) frames++;
    end
    idle(1'b1);
    if (source_valid) frames++;
    check("t3_frames", frames, 4);

    // 4: sop mid-frame discards the partial frame
    do_reset();
    for (int k = 1; k <= 5; k++) send(DW'(k), DW'(k), k == 1, 1'b0);
    check("t4_no_err", sop_err, 1'b0);
    send(DW'(100), DW'(-100), 1'b1, 1'b0);
    check("t4_err_pulse", sop_err, 1'b1);
    send(DW'(101), DW'(-101), 1'b0, 1'b0);
    check("t4_err_gone", sop_err, 1'b0);
    for (int k = 2; k < N; k++) send(DW'(100 + k), DW'(-100 - k), 1'b0, 1'b0);
    check("t4_valid", source_valid, 1'b1);
    for (int k = 0; k < N; k++) check("t4_r", source_r[k], DW'(100 + k));

    // 5: reset with two full banks and a partial one
    do_reset();
    for (int k = 0; k < 16; k++) send(DW'(k + 1), DW'(k), (k % 8) == 0, 1'b0);
    cycle(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, acc);
    for (int k = 0; k < 3; k++) send(DW'(50 + k), DW'(0), k == 0, 1'b0);
    cycle(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, acc);
    idle(1'b0);
    check("t5_valid", source_valid, 1'b0);
    check("t5_ready", sink_ready, 1'b1);
    check("t5_src_r", source_r, '0);
    check("t5_src_i", source_i, '0);
    for (int k = 0; k < N; k++) send(DW'(200 + k), DW'(k), k == 0, 1'b0);
    check("t5_fresh_valid", source_valid, 1'b1);
    check("t5_fresh_r7", source_r[7], DW'(207));

    // 6: last sample of frame B coincides with pop of frame A
    do_reset();
    for (int k = 0; k < N; k++) send(DW'(k), DW'(0), k == 0, 1'b0);
    for (int k = 0; k < N - 1; k++) send(DW'(300 + k), DW'(k), k == 0, 1'b0);
    cycle(1'b1, 1'b0, DW'(307), DW'(7), 1'b1, 1'b0, acc);
    check("t6_acc", acc, 1'b1);
    check("t6_valid", source_valid, 1'b1);
    for (int k = 0; k < N; k++) begin
      check("t6_r", source_r[k], DW'(300 + k));
      check("t6_i", source_i[k], DW'(k));
    end

    // Randomized traffic against the model
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0,
            DW'($urandom), DW'($urandom), $urandom_range(0, 2) == 0,
            $urandom_range(0, 199) == 0, acc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
